// File: rtl/u_mcb_wr_gen.sv
// u_mcb_wr_gen
// Write-side traffic generator for one MCB user write port. Each burst does
// four things in order:
//   1. fills the write data FIFO with BURST_LEN words of alternating
//      AA..AA / 55..55,
//   2. pushes one write command for the burst,
//   3. waits for the data FIFO to drain,
//   4. advances the burst address.
// The read checker on the companion read port compares against this data.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_start        level enable; bursts run back to back while high
//   cmd_full        MCB command FIFO full (holds off cmd_en)
//   wr_full         MCB write data FIFO full (holds off wr_en)
//   wr_empty        MCB write data FIFO empty
//   wr_underrun,
//   wr_error        MCB error flags, folded into sticky wr_err
//   cmd_en          command push strobe (combinational)
//   cmd_instr       always write (3'b000)
//   cmd_bl          BURST_LEN-1
//   cmd_byte_addr   burst start byte address
//   wr_en           data push strobe (combinational)
//   wr_data         pattern word
//   wr_mask         always 0 (all bytes written)
//   burst_done      one-cycle pulse per completed burst
//   burst_cnt       completed bursts, wraps
//   wr_err          sticky error flag
module u_mcb_wr_gen #(
  parameter int          BURST_LEN = 64,
  parameter logic [29:0] ADDR_INC  = 30'h400,
  parameter logic [29:0] END_ADDR  = 30'h0FFFFC00
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_start,
  input  logic         cmd_full,
  input  logic         wr_full,
  input  logic         wr_empty,
  input  logic         wr_underrun,
  input  logic         wr_error,
  output logic         cmd_en,
  output logic [2:0]   cmd_instr,
  output logic [5:0]   cmd_bl,
  output logic [29:0]  cmd_byte_addr,
  output logic         wr_en,
  output logic [127:0] wr_data,
  output logic [15:0]  wr_mask,
  output logic         burst_done,
  output logic [15:0]  burst_cnt,
  output logic         wr_err
);

  typedef enum logic [2:0] {IDLE, FILL, CMD, WAIT, DONE} state_t;

  localparam logic [127:0] PAT_A = {16{8'hAA}};
  localparam logic [6:0]   LAST  = 7'(BURST_LEN - 1);

  state_t     state, state_nxt;
  logic [6:0] word_cnt;
  // Set after the first WAIT cycle: wr_empty may still show the pre-command
  // level, so WAIT always lasts at least two cycles.
  logic       wait_cnt;

  assign cmd_instr = 3'b000;
  assign cmd_bl    = 6'(BURST_LEN - 1);
  assign wr_mask   = '0;

  // Strobes are gated with rst so that a reset aborts with no push in the
  // reset cycle itself.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    cmd_en    = 1'b0;
    case (state)
      IDLE: if (wr_start) state_nxt = FILL;
      FILL: begin
        wr_en = !wr_full && !rst;
        if (!wr_full && word_cnt == LAST) state_nxt = CMD;
      end
      CMD: begin
        cmd_en = !cmd_full && !rst;
        if (!cmd_full) state_nxt = WAIT;
      end
      WAIT: if (wait_cnt && wr_empty) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_data       <= PAT_A;
      cmd_byte_addr <= '0;
      word_cnt      <= '0;
      wait_cnt      <= 1'b0;
      burst_done    <= 1'b0;
      burst_cnt     <= '0;
      wr_err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      burst_done <= 1'b0;
      case (state)
        IDLE: if (wr_start) begin
          // The pattern restarts at AA every burst.
          wr_data  <= PAT_A;
          word_cnt <= '0;
        end
        FILL: if (!wr_full) begin
          wr_data  <= ~wr_data;
          word_cnt <= word_cnt + 7'd1;
        end
        CMD: wait_cnt <= 1'b0;
        WAIT: begin
          wait_cnt <= 1'b1;
          // Burst bookkeeping lands together with the DONE cycle, so
          // burst_done, burst_cnt and the next address are seen together.
          if (state_nxt == DONE) begin
            burst_done    <= 1'b1;
            burst_cnt     <= burst_cnt + 16'd1;
            cmd_byte_addr <= (cmd_byte_addr >= END_ADDR) ? '0
                                                         : cmd_byte_addr + ADDR_INC;
          end
        end
        default: ;
      endcase
      // Set wins over clear.
      if (wr_underrun || wr_error)      wr_err <= 1'b1;
      else if (state == IDLE && !wr_start) wr_err <= 1'b0;
    end
  end

endmodule
